// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State and grant-source encodings plus the word width.
package mem_arb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles of an outstanding memory request.
// Flags expiry once the count reaches TIMEOUT.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_cnt;

  // Holds at LIMIT so a long stall can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word memory port between fetch and data access.
// Data wins ties unless fetch has been starved STARVE_MAX grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  arb_src_t   r_src;

  logic [SW-1:0]   r_starve;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic            r_if_ack;
  logic [XLEN-1:0] r_if_rdata;
  logic            r_if_err;
  logic            r_d_ack;
  logic [XLEN-1:0] r_d_rdata;
  logic            r_d_err;

  logic            w_idle;
  logic            w_busy;
  logic            w_grant_d;
  logic            w_grant_i;
  logic            w_expired;
  logic            w_done;
  logic            w_rsp_err;
  logic [XLEN-1:0] w_rsp_data;

  assign w_idle = (r_state == IDLE);
  assign w_busy = (r_state == BUSY_I) ||
                  (r_state == BUSY_D);

  assign w_grant_d = w_idle && d_req &&
                     !(if_req && (r_starve == SMAX));
  assign w_grant_i = w_idle && if_req && !w_grant_d;

  // An ack landing on the expiry cycle still counts as success.
  assign w_done     = w_busy && (mem_ack || w_expired);
  assign w_rsp_err  = !mem_ack;
  assign w_rsp_data = (mem_ack && !r_mem_we) ?
                      mem_rdata : '0;

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .run    (w_grant_d || w_grant_i || w_busy),
    .clr    (r_state == RESP),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if ((w_idle && !if_req) || w_grant_i) begin
      r_starve <= '0;
    end else if (w_grant_d && if_req &&
                 (r_starve != SMAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src       <= SRC_I;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_grant_d) begin
        r_src       <= SRC_D;
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if (w_grant_i) begin
        r_src       <= SRC_I;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
      end
      if (w_done) begin
        r_mem_req <= 1'b0;
        if (r_src == SRC_D) begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= w_rsp_data;
          r_d_err   <= w_rsp_err;
        end else begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_rsp_data;
          r_if_err   <= w_rsp_err;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ack    = r_if_ack;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Drives and samples on the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk;
  int n_err;

  mem_port_arbiter #(
    .TIMEOUT   (8),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [5:0]  pat;
    logic        is_d;
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // reset state
    step(2);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    reset = 1'b0;
    step(1);
    check("idle_mem_req", 32'(mem_req), 32'd0);

    // single fetch, memory acks two cycles in
    if_req  = 1'b1;
    if_addr = 32'h10;
    step(1);
    check("f_mem_req", 32'(mem_req), 32'd1);
    check("f_mem_addr", mem_addr, 32'h10);
    check("f_mem_we", 32'(mem_we), 32'd0);
    step(1);
    check("f_wait_ack", 32'(if_ack), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step(1);
    check("f_if_ack", 32'(if_ack), 32'd1);
    check("f_if_rdata", if_rdata, 32'hDEADBEEF);
    check("f_if_err", 32'(if_err), 32'd0);
    check("f_req_drop", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    if_req  = 1'b0;
    step(1);
    check("f_ack_pulse", 32'(if_ack), 32'd0);

    // simultaneous: data store first, then fetch
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'h1234;
    step(1);
    check("b_mem_addr", mem_addr, 32'h20);
    check("b_mem_we", 32'(mem_we), 32'd1);
    check("b_mem_wdata", mem_wdata, 32'h1234);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step(1);
    check("b_acks", 32'({d_ack, if_ack}), 32'd2);
    check("b_d_rdata", d_rdata, 32'd0);
    check("b_d_err", 32'(d_err), 32'd0);
    mem_ack = 1'b0;
    d_req   = 1'b0;
    step(1);
    check("b_resp_gap", 32'(mem_req), 32'd0);
    step(1);
    check("b_f_mem_addr", mem_addr, 32'h40);
    check("b_f_mem_we", 32'(mem_we), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step(1);
    check("b_f_ack", 32'({d_ack, if_ack}), 32'd1);
    check("b_f_rdata", if_rdata, 32'hCAFEF00D);
    mem_ack = 1'b0;
    if_req  = 1'b0;
    step(1);

    // fetch held against continuous loads
    if_req  = 1'b1;
    if_addr = 32'h80;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h100;
    pat     = 6'b101111;
    for (int i = 0; i < 6; i++) begin
      is_d = pat[i];
      step(1);
      check("s_grant", mem_addr,
            is_d ? 32'h100 : 32'h80);
      mem_ack   = 1'b1;
      mem_rdata = 32'(i + 1);
      step(1);
      check("s_ack", 32'({d_ack, if_ack}),
            is_d ? 32'd2 : 32'd1);
      mem_ack = 1'b0;
      if (i == 5) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      step(1);
      check("s_gap", 32'(mem_req), 32'd0);
    end
    check("s_d_rdata", d_rdata, 32'd6);
    check("s_if_rdata", if_rdata, 32'd5);

    // stray ack while idle
    mem_ack   = 1'b1;
    mem_rdata = 32'h99;
    step(1);
    mem_ack = 1'b0;
    step(1);
    check("x_acks", 32'({d_ack, if_ack}), 32'd0);
    check("x_mem_req", 32'(mem_req), 32'd0);

    // timeout on a load
    d_req  = 1'b1;
    d_addr = 32'h200;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("t_req_high", 32'(mem_req), 32'd1);
      check("t_no_ack", 32'(d_ack), 32'd0);
    end
    step(1);
    check("t_req_low", 32'(mem_req), 32'd0);
    check("t_d_ack", 32'(d_ack), 32'd1);
    check("t_d_err", 32'(d_err), 32'd1);
    check("t_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    step(1);
    check("t_ack_pulse", 32'(d_ack), 32'd0);
    check("t_idle", 32'(mem_req), 32'd0);

    // ack coincident with the expiry cycle
    d_req  = 1'b1;
    d_addr = 32'h204;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("c_req_high", 32'(mem_req), 32'd1);
      if (k == 8) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
      end
    end
    step(1);
    check("c_d_ack", 32'(d_ack), 32'd1);
    check("c_d_err", 32'(d_err), 32'd0);
    check("c_d_rdata", d_rdata, 32'h5A5A5A5A);
    mem_ack = 1'b0;
    d_req   = 1'b0;
    step(1);

    // reset during a store, late ack afterwards
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h300;
    d_wdata = 32'h77;
    step(1);
    check("r_busy", 32'(mem_req), 32'd1);
    reset = 1'b1;
    d_req = 1'b0;
    step(1);
    check("r_req_low", 32'(mem_req), 32'd0);
    check("r_we_low", 32'(mem_we), 32'd0);
    check("r_no_ack", 32'(d_ack), 32'd0);
    reset = 1'b0;
    step(1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1;
    step(1);
    check("r_late_ack", 32'({d_ack, if_ack}), 32'd0);
    check("r_late_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h44;
    step(1);
    check("r_idle_grant", 32'(mem_req), 32'd1);
    check("r_idle_addr", mem_addr, 32'h44);
    mem_ack   = 1'b1;
    mem_rdata = 32'hABCD;
    step(1);
    check("r_f_ack", 32'(if_ack), 32'd1);
    check("r_f_rdata", if_rdata, 32'hABCD);
    mem_ack = 1'b0;
    if_req  = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch and data load/store. Sits between the datapath's fetch and data-access sides and the unified word memory. Serialises requests one at a time with fixed data-over-fetch priority, a fetch anti-starvation rule, and a response timeout that converts a hung memory into an error response.

## Interface
- `TIMEOUT`, 255 — max cycles `mem_req` stays high without `mem_ack` before error (1..65535)
- `STARVE_MAX`, 4 — consecutive data grants allowed while fetch is pending (>=1)
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `if_req` in 1 — fetch request, held until `if_ack`
- `if_addr` in 32 — fetch byte address, word aligned
- `if_ack` out 1 — one-cycle response pulse
- `if_rdata` out 32 — fetched word, valid with `if_ack`
- `if_err` out 1 — timeout error, valid with `if_ack`
- `d_req` in 1 — data request, held until `d_ack`
- `d_we` in 1 — 1 = store, 0 = load
- `d_addr` in 32 — data byte address, word aligned
- `d_wdata` in 32 — store data
- `d_ack`, `d_rdata`, `d_err` out 1/32/1 — as fetch side
- `mem_req` out 1 — memory request, held until `mem_ack` or timeout
- `mem_we` out 1 — write enable
- `mem_addr` out 32 — registered address
- `mem_wdata` out 32 — registered write data
- `mem_ack` in 1 — memory completion, one cycle
- `mem_rdata` in 32 — read data, valid with `mem_ack`

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. Reset: IDLE. All outputs 0. Starve and timeout counters 0.
- IDLE, no request: stay IDLE.
- IDLE, only one request pending: grant it.
- IDLE, both pending: grant data, unless starve count == `STARVE_MAX`; then grant fetch.
- On grant: latch addr/we/wdata into `mem_*` registers and go BUSY_I or BUSY_D. Fetch grants force `mem_we`=0.
- Starve counter:
  - +1 on each data grant while `if_req`=1.
  - Cleared on a fetch grant, or in any IDLE cycle with `if_req`=0.
  - Saturates at `STARVE_MAX`.
- BUSY_x: `mem_req`=1. The timeout counter increments each cycle.
  - `mem_ack`: capture `mem_rdata` (forced 0 for stores), err=0, go RESP.
  - Counter reaches `TIMEOUT` without `mem_ack`: drop `mem_req`, rdata=0, err=1, go RESP.
  - `mem_ack` in the same cycle as the timeout is taken as success.
- RESP: pulse the granted side's `x_ack` with registered rdata/err. Clear the timeout counter. Go IDLE.
- Requester protocol: keep `x_req` and fields stable from assertion through the `x_ack` cycle. Deassert no later than the cycle after `x_ack`; a `x_req` still high in IDLE is a new request.
- `mem_ack` seen in IDLE or RESP is ignored: no state change, no ack.
- Reset asserted mid-transaction:
  - Abandon it next edge and return to IDLE.
  - `mem_req` drops and no `x_ack` is issued.
  - A late `mem_ack` after reset is ignored.

## Timing
- Request seen in IDLE at cycle N: `mem_req`/`mem_addr` high from N+1.
- `mem_ack` at cycle M: `x_ack` at M+1. Earliest next grant decision at M+2, next `mem_req` at M+3.
- Minimum turnaround with zero-wait memory (`mem_ack` at N+1): ack at N+2. Back-to-back throughput is one transaction per 3 cycles.
- Timeout: `mem_req` high for exactly `TIMEOUT` cycles, `x_err` ack on the following cycle.
- All outputs registered. No combinational path from any input to any output.

## Structure
- Package `mem_arb_pkg`: state enum `arb_state_t` (IDLE, BUSY_I, BUSY_D, RESP), grant enum `arb_src_t` (SRC_I, SRC_D), word width constant `XLEN`=32.
- Sub-module `mem_timeout_counter`:
  - Parameter `TIMEOUT`.
  - Inputs `clk`, `reset`, `run`, `clr`. Output `expired`.
  - Width `$clog2(TIMEOUT+1)`.
  - `expired` is asserted in the cycle the count equals `TIMEOUT`.
- Top-level holds the FSM, starve counter and request/response registers.

## Test plan
- Single fetch, `if_addr`=0x10, memory acks 2 cycles after `mem_req` with 0xDEADBEEF -> `mem_addr`=0x10, `mem_we`=0, `if_ack` one cycle later, `if_rdata`=0xDEADBEEF, `if_err`=0.
- `if_req` and `d_req` (store 0x20 <- 0x1234) together in IDLE -> data granted first with `mem_we`=1, `mem_wdata`=0x1234, `d_rdata`=0; fetch served next.
- Fetch held high with continuous data requests, `STARVE_MAX`=4 -> exactly 4 data grants, then a fetch grant, then data resumes.
- `TIMEOUT`=8, memory never acks -> `mem_req` high 8 cycles then low; `d_ack`=1, `d_err`=1, `d_rdata`=0 next cycle; IDLE after.
- `mem_ack` coincident with the timeout cycle -> success response, err=0.
- Reset during BUSY_D, then `mem_ack` 2 cycles later -> `mem_req` low after the reset edge, no `d_ack`, late `mem_ack` ignored, state IDLE.
